// File: rtl/pll_sequencer.sv
// pll_sequencer: PLL reset/lock sequencer with synchronized lock, stable window and retry counting.
// Optional PLL_SEQ_RETRY_LIMIT_EN: stop in FAIL once MAX_RETRIES lock timeouts have occurred.
module pll_sequencer #(
  parameter int unsigned RESET_CYCLES  = 16,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned STABLE_CYCLES = 256,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       locked,
  output logic       pll_resetb,
  output logic       sys_reset,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_count
);
  typedef enum logic [2:0] {PLL_RST, WAIT_LOCK, STABLE, RUN, FAIL} state_t;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif
  localparam logic [15:0] RST_LAST = 16'(RESET_CYCLES - 1);
  localparam logic [15:0] TO_LAST  = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] ST_LAST  = 16'(STABLE_CYCLES - 1);
  state_t      state;
  logic [15:0] cnt;
  logic [1:0]  sync;
  logic        locked_s;
  logic [3:0]  retry_next;
  assign locked_s   = sync[1];
  assign retry_next = (retry_count == 4'd15) ? 4'd15 : retry_count + 4'd1;
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= PLL_RST;
      cnt         <= '0;
      sync        <= '0;
      retry_count <= '0;
    end else begin
      sync <= {sync[0], locked};
      cnt  <= cnt + 16'd1;
      case (state)
        PLL_RST: if (cnt == RST_LAST) begin
          state <= WAIT_LOCK;
          cnt   <= '0;
        end
        WAIT_LOCK: if (locked_s) begin
          state <= STABLE;
          cnt   <= '0;
        end else if (cnt == TO_LAST) begin
          retry_count <= retry_next;
          state       <= (LIMIT_EN && retry_next == 4'(MAX_RETRIES)) ? FAIL : PLL_RST;
          cnt         <= '0;
        end
        // a lock glitch restarts the whole stable window but is not a retry
        STABLE: if (!locked_s) begin
          state <= WAIT_LOCK;
          cnt   <= '0;
        end else if (cnt == ST_LAST) begin
          state <= RUN;
          cnt   <= '0;
        end
        RUN: begin
          cnt <= '0;
          if (!locked_s) state <= PLL_RST;
        end
        FAIL: cnt <= '0;
        default: begin
          state <= PLL_RST;
          cnt   <= '0;
        end
      endcase
    end
  end
  assign pll_resetb = state == WAIT_LOCK || state == STABLE || state == RUN;
  assign sys_reset  = state != RUN;
  assign ready      = state == RUN;
  assign fail       = LIMIT_EN && state == FAIL;
endmodule
